wb_port_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline WB path and a

---
 rtl/wb_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Arbitrates the register-file write port between the pipeline WB
//             path and a FIFO of long-latency results. The FIFO also tracks
//             pending destinations and resolves WAW ordering.
//  Options  : WBARB_STARVE_EN - forced drain of a starved FIFO head
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_regWrite,
    input  logic [4:0]                 pipe_rd_addr,
    input  logic [31:0]                pipe_rd_data,
    input  logic                       ll_valid,
    output logic                       ll_ready,
    input  logic [4:0]                 ll_rd_addr,
    input  logic [31:0]                ll_rd_data,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       pipe_stall,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic [DEPTH-1:0]   live_q,   live_d;
    logic [4:0]         addr_q [DEPTH];
    logic [4:0]         addr_d [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [31:0]        data_d [DEPTH];

    logic w_pipe_wr_ok;
    logic w_pipe_perf;
    logic w_head_valid;
    logic w_head_live;
    logic w_stall;
    logic w_ready;
    logic w_push;
    logic w_pop;

    assign w_pipe_wr_ok = pipe_regWrite && (pipe_rd_addr != 5'd0);
    assign w_head_valid = (count_q != '0);
    assign w_head_live  = w_head_valid && live_q[rd_ptr_q];
    assign w_ready      = !rst && (count_q < c_CNT_W'(DEPTH));
    assign w_push       = ll_valid && w_ready && (ll_rd_addr != 5'd0);
    assign w_pipe_perf  = w_pipe_wr_ok && !w_stall;
    // The head leaves the FIFO every cycle except when it is live and loses the port.
    assign w_pop        = w_head_valid && !(w_head_live && w_pipe_perf);

`ifdef WBARB_STARVE_EN
    localparam int c_SW = $clog2(MAX_WAIT + 1);

    logic [c_SW-1:0] starve_q, starve_d;

    assign w_stall = !rst && w_head_live && w_pipe_wr_ok && (starve_q == c_SW'(MAX_WAIT - 1));

    always_comb begin
        starve_d = starve_q;
        if (!w_head_valid || w_pop) begin
            starve_d = '0;
        end else if (w_head_live && w_pipe_wr_ok) begin
            starve_d = starve_q + c_SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic w_unused_cfg;

    assign w_stall      = 1'b0;
    assign w_unused_cfg = (MAX_WAIT > 0);
`endif

    // FIFO next-state: WAW kill first, then pop, then push into the free slot.
    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (w_pipe_perf) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == pipe_rd_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (w_pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_push) begin
            live_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q] = ll_rd_addr;
            data_d[wr_ptr_q] = ll_rd_data;
            wr_ptr_d         = wr_ptr_q + c_PTR_W'(1);
        end
        count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (rst) begin
            rf_we = 1'b0;
        end else if (w_stall) begin
            rf_we    = 1'b1;
            rf_waddr = addr_q[rd_ptr_q];
            rf_wdata = data_q[rd_ptr_q];
        end else if (w_pipe_wr_ok) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd_addr;
            rf_wdata = pipe_rd_data;
        end else if (w_head_live) begin
            rf_we    = 1'b1;
            rf_waddr = addr_q[rd_ptr_q];
            rf_wdata = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == rs1_addr) && (rs1_addr != 5'd0)) begin
                rs1_pending = 1'b1;
            end
            if (live_q[i] && (addr_q[i] == rs2_addr) && (rs2_addr != 5'd0)) begin
                rs2_pending = 1'b1;
            end
        end
    end

    assign ll_ready   = w_ready;
    assign pipe_stall = w_stall;
    assign buf_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter (DEPTH=4,
//             MAX_WAIT=8); the forced-drain case follows WBARB_STARVE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_regWrite;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd_addr;
    logic [31:0] ll_rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [2:0]  buf_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_regWrite (pipe_regWrite),
        .pipe_rd_addr  (pipe_rd_addr),
        .pipe_rd_data  (pipe_rd_data),
        .ll_valid      (ll_valid),
        .ll_ready      (ll_ready),
        .ll_rd_addr    (ll_rd_addr),
        .ll_rd_data    (ll_rd_data),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_pending   (rs1_pending),
        .rs2_pending   (rs2_pending),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pipe_stall    (pipe_stall),
        .buf_count     (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic preg, input logic [4:0] paddr, input logic [31:0] pdata,
                         input logic llv, input logic [4:0] laddr, input logic [31:0] ldata);
        @(negedge clk);
        pipe_regWrite = preg;
        pipe_rd_addr  = paddr;
        pipe_rd_data  = pdata;
        ll_valid      = llv;
        ll_rd_addr    = laddr;
        ll_rd_data    = ldata;
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check_value({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
        check_value({tag, "_addr"}, {27'd0, rf_waddr}, {27'd0, a});
        check_value({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        rst           = 1'b1;
        pipe_regWrite = 1'b0;
        pipe_rd_addr  = 5'd0;
        pipe_rd_data  = 32'd0;
        ll_valid      = 1'b0;
        ll_rd_addr    = 5'd0;
        ll_rd_data    = 32'd0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;

        // Reset state
        #1;
        check_rf("rst", 1'b0, 5'd0, 32'd0);
        check_value("rst_ll_ready", {31'd0, ll_ready}, 32'd0);
        check_value("rst_count", {29'd0, buf_count}, 32'd0);
        check_value("rst_stall", {31'd0, pipe_stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: pipeline write on empty FIFO, zero latency
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        check_rf("t1", 1'b1, 5'd5, 32'h11);
        check_value("t1_ll_ready", {31'd0, ll_ready}, 32'd1);

        // 2: long-latency push drains next cycle; pipe write to x0 is an idle slot
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        check_value("t2_nobypass_we", {31'd0, rf_we}, 32'd0);
        check_value("t2_count0", {29'd0, buf_count}, 32'd0);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        check_rf("t2_drain", 1'b1, 5'd7, 32'hAA);
        check_value("t2_count1", {29'd0, buf_count}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        check_value("t2_x0push_we", {31'd0, rf_we}, 32'd0);
        check_value("t2_count_after", {29'd0, buf_count}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_value("t2_x0_count", {29'd0, buf_count}, 32'd0);

        // 3: fill to DEPTH under pipeline pressure, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'(100 + i), 1'b1, 5'(10 + i), 32'(32'hA0 + i));
            check_value("t3_fill_ready", {31'd0, ll_ready}, 32'd1);
            check_rf("t3_fill_rf", 1'b1, 5'd1, 32'(100 + i));
        end
        drive(1'b1, 5'd1, 32'd200, 1'b0, 5'd0, 32'd0);
        check_value("t3_full_count", {29'd0, buf_count}, 32'd4);
        check_value("t3_full_ready", {31'd0, ll_ready}, 32'd0);
        check_rf("t3_full_rf", 1'b1, 5'd1, 32'd200);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_rf("t3_drain", 1'b1, 5'(10 + i), 32'(32'hA0 + i));
            check_value("t3_drain_count", {29'd0, buf_count}, 32'(4 - i));
            check_value("t3_drain_ready", {31'd0, ll_ready}, (i == 0) ? 32'd0 : 32'd1);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_value("t3_empty_we", {31'd0, rf_we}, 32'd0);
        check_value("t3_empty_count", {29'd0, buf_count}, 32'd0);

        // 4: WAW kill - newer pipeline value wins, stale entry popped silently
        rs1_addr = 5'd9;
        rs2_addr = 5'd0;
        drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd9, 32'h1);
        check_rf("t4_push_rf", 1'b1, 5'd4, 32'h55);
        check_value("t4_pend_before", {31'd0, rs1_pending}, 32'd0);
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        check_value("t4_pend_live", {31'd0, rs1_pending}, 32'd1);
        check_value("t4_rs2_x0", {31'd0, rs2_pending}, 32'd0);
        check_rf("t4_kill_rf", 1'b1, 5'd9, 32'h2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_value("t4_pend_drop", {31'd0, rs1_pending}, 32'd0);
        check_value("t4_silent_we", {31'd0, rf_we}, 32'd0);
        check_value("t4_dead_count", {29'd0, buf_count}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_value("t4_final_we", {31'd0, rf_we}, 32'd0);
        check_value("t4_final_count", {29'd0, buf_count}, 32'd0);
        rs1_addr = 5'd0;

        // 5: starved head under continuous pipeline writes
        drive(1'b1, 5'd2, 32'd0, 1'b1, 5'd3, 32'h33);
        check_rf("t5_push_rf", 1'b1, 5'd2, 32'd0);
`ifdef WBARB_STARVE_EN
        for (int b = 1; b <= 8; b++) begin
            drive(1'b1, 5'd2, 32'(b), 1'b0, 5'd0, 32'd0);
            if (b < 8) begin
                check_value("t5_no_stall", {31'd0, pipe_stall}, 32'd0);
                check_rf("t5_blocked_rf", 1'b1, 5'd2, 32'(b));
            end else begin
                check_value("t5_stall", {31'd0, pipe_stall}, 32'd1);
                check_rf("t5_forced_rf", 1'b1, 5'd3, 32'h33);
            end
        end
        drive(1'b1, 5'd2, 32'h99, 1'b0, 5'd0, 32'd0);
        check_value("t5_after_stall", {31'd0, pipe_stall}, 32'd0);
        check_rf("t5_after_rf", 1'b1, 5'd2, 32'h99);
        check_value("t5_after_count", {29'd0, buf_count}, 32'd0);
`else
        for (int b = 1; b <= 10; b++) begin
            drive(1'b1, 5'd2, 32'(b), 1'b0, 5'd0, 32'd0);
            check_value("t5_no_stall", {31'd0, pipe_stall}, 32'd0);
            check_rf("t5_blocked_rf", 1'b1, 5'd2, 32'(b));
        end
        check_value("t5_held_count", {29'd0, buf_count}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_rf("t5_drain_rf", 1'b1, 5'd3, 32'h33);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_value("t5_after_count", {29'd0, buf_count}, 32'd0);
`endif

        // 6: asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 32'd7, 1'b1, 5'(20 + i), 32'(32'hC0 + i));
        end
        drive(1'b1, 5'd1, 32'd8, 1'b0, 5'd0, 32'd0);
        rs1_addr = 5'd21;
        #1;
        check_value("t6_pre_count", {29'd0, buf_count}, 32'd3);
        check_value("t6_pre_pend", {31'd0, rs1_pending}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_value("t6_rst_count", {29'd0, buf_count}, 32'd0);
        check_value("t6_rst_we", {31'd0, rf_we}, 32'd0);
        check_value("t6_rst_pend", {31'd0, rs1_pending}, 32'd0);
        check_value("t6_rst_ready", {31'd0, ll_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check_value("t6_post_we", {31'd0, rf_we}, 32'd0);
            check_value("t6_post_count", {29'd0, buf_count}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
